// File: rtl/regfile_2r1w.sv
// Parametrised WIDTH x DEPTH register file with two registered read ports and one write port.
// Define REGFILE_BYPASS_EN to forward same-edge write data to reads; otherwise reads see the old contents.
module regfile_2r1w #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  output logic              rvalid1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2,
  output logic              rvalid2
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_reg [DEPTH];
  logic              write_ok;

  logic [ADDR_W-1:0] raddr_a    [2];
  logic              re_a       [2];
  logic [WIDTH-1:0]  rdata_reg  [2];
  logic              rvalid_reg [2];

  assign write_ok = we && ({1'b0, waddr} < DEPTH_L) && !((ZERO_REG != 0) && (waddr == '0));

  assign raddr_a[0] = raddr1;
  assign raddr_a[1] = raddr2;
  assign re_a[0]    = re1;
  assign re_a[1]    = re2;
  assign rdata1     = rdata_reg[0];
  assign rdata2     = rdata_reg[1];
  assign rvalid1    = rvalid_reg[0];
  assign rvalid2    = rvalid_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (write_ok && (waddr == ADDR_W'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end

    for (gi = 0; gi < 2; gi++) begin : g_port
      logic             rd_ok;
      logic [WIDTH-1:0] rdata_next;

      assign rd_ok = ({1'b0, raddr_a[gi]} < DEPTH_L) &&
                     !((ZERO_REG != 0) && (raddr_a[gi] == '0));

      always_comb begin
        rdata_next = '0;
        if (rd_ok) begin
          rdata_next = mem_reg[raddr_a[gi]];
`ifdef REGFILE_BYPASS_EN
          // write_ok already excludes ignored addresses, so they are never forwarded
          if (write_ok && (waddr == raddr_a[gi])) begin
            rdata_next = wdata;
          end
`endif
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg[gi]  <= '0;
          rvalid_reg[gi] <= 1'b0;
        end else begin
          rvalid_reg[gi] <= re_a[gi];
          if (re_a[gi]) begin
            rdata_reg[gi] <= rdata_next;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w (DEPTH=12, ZERO_REG=1): directed steps then random traffic
// against an array-based reference model.
module tb_regfile_2r1w;

  localparam int W = 16;
  localparam int D = 12;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst, we, re1, re2;
  logic [A-1:0] waddr, raddr1, raddr2;
  logic [W-1:0] wdata, rdata1, rdata2;
  logic         rvalid1, rvalid2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model [16];
  logic [W-1:0] exp_d1, exp_d2;
  logic         exp_v1, exp_v2;

  regfile_2r1w #(.WIDTH(W), .DEPTH(D), .ADDR_W(A), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .rvalid1(rvalid1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .rvalid2(rvalid2)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_value(input int a, input logic w, input int wa,
                                             input logic [W-1:0] wd);
    if (a >= D || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (w && wa == a) return wd;
`endif
    return model[a];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, expv);
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic [A-1:0] wa, input logic [W-1:0] wd,
                     input logic e1, input logic [A-1:0] a1,
                     input logic e2, input logic [A-1:0] a2, input string tag);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) model[i] = '0;
      exp_d1 = '0; exp_d2 = '0; exp_v1 = 1'b0; exp_v2 = 1'b0;
    end else begin
      if (e1) exp_d1 = ref_value(int'(a1), w, int'(wa), wd);
      if (e2) exp_d2 = ref_value(int'(a2), w, int'(wa), wd);
      exp_v1 = e1;
      exp_v2 = e2;
      if (w && int'(wa) < D && wa != 0) model[wa] = wd;
    end
    #1;
    chk({tag, ".rdata1"}, rdata1, exp_d1);
    chk({tag, ".rdata2"}, rdata2, exp_d2);
    chk({tag, ".rvalid1"}, {15'b0, rvalid1}, {15'b0, exp_v1});
    chk({tag, ".rvalid2"}, {15'b0, rvalid2}, {15'b0, exp_v2});
    $display("cyc %-10s rst=%b we=%b wa=%0d wd=%h | r1 %b/%0d -> %h v%b | r2 %b/%0d -> %h v%b",
             tag, r, w, wa, wd, e1, a1, rdata1, rvalid1, e2, a2, rdata2, rvalid2);
  endtask

  initial begin
    // Reset, with reads requested during reset that must not produce rvalid
    cyc(1, 0, 0, 0, 1, 5, 1, 5, "reset0");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset1");
    // Preload then reset clears it
    cyc(0, 1, 5, 16'h1234, 0, 0, 0, 0, "pre5");
    cyc(1, 0, 0, 0, 1, 5, 1, 5, "rst_mid");
    cyc(0, 0, 0, 0, 1, 5, 0, 0, "rd5");
    // Basic write/read, then hold
    cyc(0, 1, 3, 16'hBEEF, 0, 0, 0, 0, "wr3");
    cyc(0, 0, 0, 0, 1, 3, 1, 3, "rd3");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "hold3");
    // Same-edge hazard
    cyc(0, 1, 7, 16'h1111, 0, 0, 0, 0, "wr7a");
    cyc(0, 1, 7, 16'h2222, 0, 0, 1, 7, "haz7");
    cyc(0, 0, 0, 0, 1, 7, 1, 7, "rd7");
    // Hardwired zero register
    cyc(0, 1, 0, 16'hFFFF, 1, 0, 1, 0, "zero_wr");
    cyc(0, 0, 0, 0, 1, 0, 1, 0, "zero_rd");
    // Out-of-range write and read
    cyc(0, 1, 13, 16'hAAAA, 1, 13, 0, 0, "oor_wr");
    cyc(0, 0, 0, 0, 1, 13, 1, 15, "oor_rd");
    for (int i = 0; i < D; i += 2)
      cyc(0, 0, 0, 0, 1, 4'(i), 1, 4'(i + 1), "scan");
    // Reset drops a concurrent write
    cyc(1, 1, 4, 16'h5555, 0, 0, 0, 0, "rst_wr4");
    cyc(0, 0, 0, 0, 1, 4, 1, 4, "rd4");
    // Random traffic
    for (int n = 0; n < 400; n++)
      cyc(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom), 16'($urandom),
          1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), "rand");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
